gcd_sweep_master: RTL and testbench
===================================

# gcd_sweep_master

- Hardware initiator for the GCD unit's `start`/`done` handshake.
- Sweeps every operand pair `(a, b)` with `a` and `b` each in `1..MAX`, with `a` as the outer loop.
  - For each pair: presents the operands, pulses start, waits for done or a timeout, then emits the result on a ready/valid stream.
- Sits between the GCD datapath and an on-chip result sink or checker, replacing bench-driven stimulus for in-system self-test.

## Interface

Parameters:
- `WIDTH`, default 8: operand and result width.
- `MAX`, default 15: sweep upper bound. Legal range is `1..2**WIDTH-1`.
- `TIMEOUT_CYC`, default 1024: maximum number of WAIT cycles per pair. Must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  one-cycle request to begin a sweep. Ignored while `busy`.
- `busy`  out  1  high from the cycle after `run` is accepted until FINISH.
- `sweep_done`  out  1  one-cycle pulse in FINISH.
- `gcd_start`  out  1  start pulse to the GCD unit.
- `gcd_a`, `gcd_b`  out  WIDTH  operands to the GCD unit.
- `gcd_done`  in  1  GCD completion level.
- `gcd_result`  in  WIDTH  GCD value.
- `res_valid`  out  1  result-stream valid.
- `res_ready`  in  1  result-stream ready.
- `res_a`, `res_b`, `res_gcd`  out  WIDTH  emitted operands and result.
- `res_timeout`  out  1  set when the emitted entry timed out.
- `pair_cnt`  out  2*WIDTH  number of pairs emitted in the current sweep.
- `timeout_cnt`  out  16  number of timeouts in the current sweep. Saturates at 16'hFFFF.

## Operation

States: IDLE, ISSUE, GUARD, WAIT, EMIT, GAP, FINISH.

- **IDLE**
  - On `run`: set `gcd_a=1`, `gcd_b=1`, clear `pair_cnt` and `timeout_cnt`, go to ISSUE.
- **ISSUE**
  - `gcd_start=1` for exactly this cycle; clear the timer; go to GUARD.
- **GUARD**
  - One cycle in which `gcd_done` is ignored.
  - This is required because the GCD unit holds `done` high from the previous operation until it sees start.
  - Go to WAIT.
- **WAIT**
  - If `gcd_done=1`:
    - capture `res_gcd=gcd_result`, `res_timeout=0`, `res_a/res_b=gcd_a/gcd_b`;
    - go to EMIT.
  - Else if timer == `TIMEOUT_CYC-1`:
    - capture `res_gcd=0`, `res_timeout=1`;
    - increment `timeout_cnt` (saturating);
    - go to EMIT.
  - Else increment the timer.
- **EMIT**
  - `res_valid=1`; all `res_*` fields stay stable until `res_ready`.
  - On handshake: increment `pair_cnt`, go to GAP.
- **GAP**
  - One idle cycle.
  - If `(gcd_a, gcd_b) == (MAX, MAX)`, go to FINISH.
  - Otherwise advance the operands:
    - if `gcd_b == MAX`, set `gcd_b=1` and `gcd_a=gcd_a+1`;
    - else set `gcd_b=gcd_b+1`;
    - then go to ISSUE.
- **FINISH**
  - `sweep_done=1`, `busy=0`, go to IDLE.
  - `res_*` and the counters hold their final values until the next `run`.

## Timing

- Reset values: every output is 0, and the state is IDLE. Reset takes effect asynchronously at any point, including mid-handshake.
  - `gcd_start` drops immediately.
  - No partial result is emitted.
- `gcd_a`/`gcd_b` are stable from ISSUE through GAP. They change only in GAP or IDLE.
- `gcd_start` is never high for two consecutive cycles.
  - Minimum spacing between starts is 5 cycles (ISSUE, GUARD, WAIT, EMIT, GAP) with zero DUT latency and `res_ready=1`.
- Per-pair latency from ISSUE to `res_valid` is 2 + k cycles, where k is the number of WAIT cycles (1..`TIMEOUT_CYC`).
- Simultaneous `gcd_done` and timer expiry in WAIT: done wins, and no timeout is counted.
- `run` asserted in any state other than IDLE is ignored.

## Structure

Shared package `gcd_pkg`:
- state enum `sweep_state_e`;
- default constants `GCD_WIDTH=8`, `GCD_TIMEOUT=1024`.

Sub-module `sweep_timeout_ctr`:
- loadable cycle counter with `clr`, `en`, and an `expired` output at `TIMEOUT_CYC-1`.

All other logic lives in one FSM plus registers.

## Test plan

1. **Basic sweep.** `MAX=3`, model GCD with 2-cycle latency, `res_ready=1`, pulse `run`.
   - Required: 9 results in order (1,1,1), (1,2,1), (1,3,1), (2,1,1), (2,2,2), (2,3,1), (3,1,1), (3,2,1), (3,3,3).
   - Required: one `sweep_done` pulse; `pair_cnt=9`; `timeout_cnt=0`.
2. **Stale done.** Model holds `done=1` until the next start, with 4-cycle latency.
   - Required: no capture during GUARD; every `res_gcd` is correct, e.g. (2,2) gives 2, not the previous value 1.
3. **Timeout.** `TIMEOUT_CYC=16`; model never asserts done for (2,2).
   - Required: entry (2,2,0) with `res_timeout=1` after exactly 16 WAIT cycles; `timeout_cnt=1`; sweep continues to (3,3).
4. **Backpressure.** Hold `res_ready=0` for 5 cycles during EMIT.
   - Required: `res_valid` held; `res_*` unchanged; no `gcd_start` until the handshake plus GAP.
5. **Reset mid-operation.** Drive `reset=0` during WAIT of (2,1).
   - Required: outputs go to 0 immediately and asynchronously.
   - Required: after release, `run` restarts at (1,1) with `pair_cnt=0`.
6. **`run` while busy.** Pulse `run` during a sweep.
   - Required: ignored; exactly one `sweep_done`; 9 results for `MAX=3`.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD sweep initiator.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH   = 8;
  localparam int unsigned GCD_TIMEOUT = 1024;
  localparam int unsigned GCD_MAX     = 15;
  localparam int unsigned TMO_CNT_W   = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_GUARD  = 3'd2,
    S_WAIT   = 3'd3,
    S_EMIT   = 3'd4,
    S_GAP    = 3'd5,
    S_FINISH = 3'd6
  } sweep_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [TMO_CNT_W-1:0] sat_inc16(input logic [TMO_CNT_W-1:0] v);
    return (v == {TMO_CNT_W{1'b1}}) ? v : v + TMO_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sweep_timeout_ctr.sv
// Per-pair WAIT cycle counter; expired is high once the count reaches TIMEOUT_CYC-1.
module sweep_timeout_ctr
  import gcd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = GCD_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register; expired is registered from the next count so it lines up with cnt_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      expired <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/gcd_sweep_master.sv
// Drives the GCD unit over every (a, b) in 1..MAX x 1..MAX and streams the results.
module gcd_sweep_master
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH       = GCD_WIDTH,
  parameter int unsigned MAX         = GCD_MAX,
  parameter int unsigned TIMEOUT_CYC = GCD_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   gcd_start,
  output logic [WIDTH-1:0]       gcd_a,
  output logic [WIDTH-1:0]       gcd_b,
  input  logic                   gcd_done,
  input  logic [WIDTH-1:0]       gcd_result,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_a,
  output logic [WIDTH-1:0]       res_b,
  output logic [WIDTH-1:0]       res_gcd,
  output logic                   res_timeout,
  output logic [2*WIDTH-1:0]     pair_cnt,
  output logic [TMO_CNT_W-1:0]   timeout_cnt
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  sweep_state_e state_q, state_d;

  logic [WIDTH-1:0]     gcd_a_d, gcd_b_d;
  logic [WIDTH-1:0]     res_a_d, res_b_d, res_gcd_d;
  logic                 res_timeout_d;
  logic [PW-1:0]        pair_cnt_d;
  logic [TMO_CNT_W-1:0] timeout_cnt_d;
  logic                 timer_clr_c, timer_en_c, timer_expired;

  // WAIT-cycle timer, cleared in ISSUE and advanced only while still waiting.
  sweep_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr_c),
    .en      (timer_en_c),
    .expired (timer_expired)
  );

  // Next-state and next-register values for the sweep sequencer.
  always_comb begin
    state_d       = state_q;
    gcd_a_d       = gcd_a;
    gcd_b_d       = gcd_b;
    res_a_d       = res_a;
    res_b_d       = res_b;
    res_gcd_d     = res_gcd;
    res_timeout_d = res_timeout;
    pair_cnt_d    = pair_cnt;
    timeout_cnt_d = timeout_cnt;
    timer_clr_c   = 1'b0;
    timer_en_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          gcd_a_d       = ONE_V;
          gcd_b_d       = ONE_V;
          pair_cnt_d    = '0;
          timeout_cnt_d = '0;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_clr_c = 1'b1;
        state_d     = S_GUARD;
      end
      // The GCD unit still shows the previous done here; skip it.
      S_GUARD: begin
        state_d = S_WAIT;
      end
      // Done has priority over a simultaneous timer expiry.
      S_WAIT: begin
        if (gcd_done) begin
          res_a_d       = gcd_a;
          res_b_d       = gcd_b;
          res_gcd_d     = gcd_result;
          res_timeout_d = 1'b0;
          state_d       = S_EMIT;
        end else if (timer_expired) begin
          res_a_d       = gcd_a;
          res_b_d       = gcd_b;
          res_gcd_d     = '0;
          res_timeout_d = 1'b1;
          timeout_cnt_d = sat_inc16(timeout_cnt);
          state_d       = S_EMIT;
        end else begin
          timer_en_c = 1'b1;
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          pair_cnt_d = pair_cnt + PW'(1);
          state_d    = S_GAP;
        end
      end
      // b is the inner loop; a advances when b wraps.
      S_GAP: begin
        if ((gcd_a == MAX_V) && (gcd_b == MAX_V)) begin
          state_d = S_FINISH;
        end else begin
          if (gcd_b == MAX_V) begin
            gcd_b_d = ONE_V;
            gcd_a_d = gcd_a + ONE_V;
          end else begin
            gcd_b_d = gcd_b + ONE_V;
          end
          state_d = S_ISSUE;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; strobes are registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      gcd_start   <= 1'b0;
      gcd_a       <= '0;
      gcd_b       <= '0;
      res_valid   <= 1'b0;
      res_a       <= '0;
      res_b       <= '0;
      res_gcd     <= '0;
      res_timeout <= 1'b0;
      pair_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      state_q     <= state_d;
      busy        <= (state_d != S_IDLE) && (state_d != S_FINISH);
      sweep_done  <= (state_d == S_FINISH);
      gcd_start   <= (state_d == S_ISSUE);
      gcd_a       <= gcd_a_d;
      gcd_b       <= gcd_b_d;
      res_valid   <= (state_d == S_EMIT);
      res_a       <= res_a_d;
      res_b       <= res_b_d;
      res_gcd     <= res_gcd_d;
      res_timeout <= res_timeout_d;
      pair_cnt    <= pair_cnt_d;
      timeout_cnt <= timeout_cnt_d;
    end
  end

endmodule

// File: tb/tb_gcd_sweep_master.sv
// Directed bench for gcd_sweep_master with MAX=3, TIMEOUT_CYC=16 and a behavioural GCD unit.
module tb_gcd_sweep_master;

  localparam int W    = 8;
  localparam int MAXV = 3;
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          busy, sweep_done, gcd_start;
  logic [W-1:0]  gcd_a, gcd_b;
  logic          gcd_done;
  logic [W-1:0]  gcd_result;
  logic          res_valid, res_ready;
  logic [W-1:0]  res_a, res_b, res_gcd;
  logic          res_timeout;
  logic [2*W-1:0] pair_cnt;
  logic [15:0]   timeout_cnt;

  gcd_sweep_master #(.WIDTH(W), .MAX(MAXV), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .run(run), .busy(busy), .sweep_done(sweep_done),
    .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_done(gcd_done),
    .gcd_result(gcd_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_a(res_a), .res_b(res_b), .res_gcd(res_gcd), .res_timeout(res_timeout),
    .pair_cnt(pair_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural GCD unit ----------------
  int     lat;
  bit     block22;
  logic [W-1:0] ma, mb;
  int     mcnt;
  logic   mpend, start_q;

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // done is a level that only drops one cycle after start is seen.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      gcd_done <= 1'b0; gcd_result <= '0; mpend <= 1'b0; mcnt <= 0;
      start_q <= 1'b0; ma <= '0; mb <= '0;
    end else begin
      start_q <= gcd_start;
      if (start_q) gcd_done <= 1'b0;
      if (gcd_start) begin
        ma <= gcd_a; mb <= gcd_b; mcnt <= lat; mpend <= 1'b1;
      end else if (mpend) begin
        if (mcnt <= 1) begin
          mpend <= 1'b0;
          if (!(block22 && ma == 2 && mb == 2)) begin
            gcd_done   <= 1'b1;
            gcd_result <= gcd_f(ma, mb);
          end
        end else begin
          mcnt <= mcnt - 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  typedef struct { logic [W-1:0] a, b, g; logic to; int lat; } ent_t;
  ent_t got[$];
  int   cyc = 0, start_cyc = 0, cur_lat = 0, min_gap = 1000000, nstarts = 0, done_pulses = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (gcd_start) begin
        if (nstarts > 0 && (cyc - start_cyc) < min_gap) min_gap = cyc - start_cyc;
        start_cyc = cyc;
        nstarts++;
      end
      if (res_valid && !prev_valid) cur_lat = cyc - start_cyc;
      if (res_valid && res_ready) got.push_back('{res_a, res_b, res_gcd, res_timeout, cur_lat});
      if (sweep_done) done_pulses++;
      prev_valid = res_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- checking ----------------
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  typedef struct { logic [W-1:0] a, b, g; } exp_t;
  typedef struct { int lat; bit blk; bit xrun; int exp_tmo; } scen_t;
  exp_t  ex[9];
  scen_t scen[4];

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done_pulses > d0) begin ok = 1'b1; break; end
    end
  endtask

  // Compare the 9 entries of one sweep against the hand table.
  task automatic chk_entries(input string tag, input int base, input int l, input bit blk);
    int eg, eto, el;
    chk({tag, "_count"}, got.size() - base, 9);
    for (int i = 0; i < 9; i++) begin
      eg  = int'(ex[i].g);
      eto = 0;
      el  = 2 + l;
      if (blk && ex[i].a == 2 && ex[i].b == 2) begin eg = 0; eto = 1; el = 2 + TMO; end
      if (base + i < got.size()) begin
        chk($sformatf("%s_entry%0d", tag, i),
            int'({got[base+i].a, got[base+i].b, got[base+i].g, got[base+i].to}),
            int'({ex[i].a, ex[i].b, W'(eg), 1'(eto)}));
        chk($sformatf("%s_lat%0d", tag, i), got[base+i].lat, el);
      end else begin
        chk($sformatf("%s_entry%0d_missing", tag, i), -1, int'({ex[i].a, ex[i].b, W'(eg), 1'(eto)}));
      end
    end
  endtask

  initial begin
    int  base, d0;
    bit  ok;

    ex[0] = '{1,1,1}; ex[1] = '{1,2,1}; ex[2] = '{1,3,1};
    ex[3] = '{2,1,1}; ex[4] = '{2,2,2}; ex[5] = '{2,3,1};
    ex[6] = '{3,1,1}; ex[7] = '{3,2,1}; ex[8] = '{3,3,3};
    // lat, block (2,2), extra run pulses, expected timeouts
    scen[0] = '{2, 1'b0, 1'b0, 0};
    scen[1] = '{4, 1'b0, 1'b0, 0};
    scen[2] = '{3, 1'b1, 1'b0, 1};
    scen[3] = '{2, 1'b0, 1'b1, 0};

    reset = 1'b0; run = 1'b0; res_ready = 1'b1; lat = 2; block22 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", int'({busy, sweep_done, gcd_start, res_valid, res_timeout}), 0);
    chk("reset_data", int'({gcd_a, gcd_b, res_a, res_b}), 0);
    chk("reset_cnt", int'({res_gcd, pair_cnt}), 0);
    chk("reset_tmo", int'(timeout_cnt), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Table-driven sweeps: basic, stale done, timeout, run while busy.
    for (int s = 0; s < 4; s++) begin
      lat = scen[s].lat; block22 = scen[s].blk;
      base = got.size(); d0 = done_pulses;
      run = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
      chk($sformatf("s%0d_busy_start", s), int'(busy), 1);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        @(posedge clk); #1;
        run = scen[s].xrun && (i == 10 || i == 40);
        if (done_pulses > d0) begin ok = 1'b1; break; end
      end
      run = 1'b0;
      chk($sformatf("s%0d_finished", s), int'(ok), 1);
      repeat (8) @(posedge clk);
      #1;
      chk($sformatf("s%0d_done_pulses", s), done_pulses - d0, 1);
      chk($sformatf("s%0d_busy_end", s), int'(busy), 0);
      chk($sformatf("s%0d_pair_cnt", s), int'(pair_cnt), 9);
      chk($sformatf("s%0d_timeout_cnt", s), int'(timeout_cnt), scen[s].exp_tmo);
      chk_entries($sformatf("s%0d", s), base, scen[s].lat, scen[s].blk);
    end

    // Backpressure on the first entry.
    lat = 2; block22 = 1'b0;
    base = got.size(); d0 = done_pulses;
    res_ready = 1'b0; run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (res_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("bp_valid_seen", int'(ok), 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_hold%0d", i), int'(res_valid), 1);
      chk($sformatf("bp_data_hold%0d", i), int'({res_a, res_b, res_gcd, res_timeout}),
          int'({8'd1, 8'd1, 8'd1, 1'b0}));
      chk($sformatf("bp_no_start%0d", i), int'(gcd_start), 0);
      if (i == 4) res_ready = 1'b1;
      @(posedge clk); #1;
    end
    chk("bp_gap_no_start", int'(gcd_start), 0);
    chk("bp_gap_valid_low", int'(res_valid), 0);
    chk("bp_pair_cnt_1", int'(pair_cnt), 1);
    @(posedge clk); #1;
    chk("bp_next_start", int'(gcd_start), 1);
    chk("bp_next_ops", int'({gcd_a, gcd_b}), int'({8'd1, 8'd2}));
    wait_done(d0, ok);
    chk("bp_finished", int'(ok), 1);
    chk_entries("bp", base, 2, 1'b0);

    // Asynchronous reset during WAIT of (2,1), then a clean restart.
    repeat (3) @(posedge clk);
    #1;
    base = got.size(); d0 = done_pulses;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (gcd_start && gcd_a == 2 && gcd_b == 1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("rst_reached_21", int'(ok), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy_before", int'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_ctrl", int'({busy, sweep_done, gcd_start, res_valid, res_timeout}), 0);
    chk("rst_async_ops", int'({gcd_a, gcd_b}), 0);
    chk("rst_async_res", int'({res_a, res_b, res_gcd}), 0);
    chk("rst_async_cnt", int'({pair_cnt, timeout_cnt}), 0);
    chk("rst_no_partial", got.size() - base, 3);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    base = got.size();
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    chk("rst_restart_start", int'(gcd_start), 1);
    chk("rst_restart_ops", int'({gcd_a, gcd_b}), int'({8'd1, 8'd1}));
    chk("rst_restart_pair_cnt", int'(pair_cnt), 0);
    wait_done(d0, ok);
    chk("rst_restart_finished", int'(ok), 1);
    chk_entries("rst", base, 2, 1'b0);

    chk("start_spacing_ok", int'(min_gap >= 5), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
